// File: rtl/decoder_scan_mux_if.sv
// Write port of decoder_scan_mux: valid/ready transfer of one coded word into a channel's shadow.
interface decoder_scan_mux_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic           in_valid;
  logic [ChW-1:0] in_ch;
  logic [SEL_W:0] in_code;
  logic           in_ready;

  modport master (
    output in_valid,
    output in_ch,
    output in_code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_ch,
    input  in_code,
    output in_ready
  );
endinterface

// File: rtl/decoder_scan_mux.sv
// Time-multiplexed one-hot decoder: scans N_CH coded words at a fixed dwell, committing shadow
// writes to the displayed set only at frame boundaries so a frame never tears.
module decoder_scan_mux #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  decoder_scan_mux_if.slave     wr,
  output logic [N_CH-1:0]       ch_sel,
  output logic [2**SEL_W-1:0]   dec_out,
  output logic                  frame_done
);

  localparam int unsigned ChW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CodeW = SEL_W + 1;
  localparam int unsigned DecW  = 2**SEL_W;
  localparam logic [ChW-1:0]   LastIdx  = ChW'(N_CH - 1);
  localparam logic [PcntW-1:0] LastPcnt = PcntW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e           state_q, state_d;
  logic [ChW-1:0]   idx_q, idx_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [CodeW-1:0] shadow_q [N_CH];
  logic [CodeW-1:0] shadow_d [N_CH];
  logic [CodeW-1:0] active_q [N_CH];
  logic [CodeW-1:0] active_d [N_CH];
  logic [CodeW-1:0] cur_code;
  logic             load_active;
  logic             wr_fire;

  assign wr.in_ready = (state_q != StCommit) && !reset;
  assign wr_fire     = wr.in_valid && wr.in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pcnt_d      = pcnt_q;
    load_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Active tracks shadow continuously so a restart shows current contents.
        load_active = 1'b1;
        idx_d       = '0;
        pcnt_d      = '0;
        if (en) state_d = StScan;
      end
      StScan: begin
        if (!en) begin
          state_d = StIdle;
          idx_d   = '0;
          pcnt_d  = '0;
        end else if (pcnt_q == LastPcnt) begin
          pcnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StCommit;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      StCommit: begin
        load_active = 1'b1;
        idx_d       = '0;
        pcnt_d      = '0;
        state_d     = en ? StScan : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Channel numbers >= N_CH never match an index, so such writes vanish.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire && (wr.in_ch == ChW'(i))) shadow_d[i] = wr.in_code;
      active_d[i] = load_active ? shadow_q[i] : active_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pcnt_q  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  always_comb begin
    cur_code = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (idx_q == ChW'(i)) cur_code = active_q[i];
    end
  end

  always_comb begin
    ch_sel  = '0;
    dec_out = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_sel[i] = (state_q == StScan) && (idx_q == ChW'(i));
    end
    for (int unsigned j = 0; j < DecW; j++) begin
      dec_out[j] = (state_q == StScan) && cur_code[SEL_W] &&
                   (cur_code[SEL_W-1:0] == SEL_W'(j));
    end
  end

  assign frame_done = (state_q == StCommit);

endmodule

// File: tb/tb_decoder_scan_mux.sv
// Directed bench for decoder_scan_mux with the default 4 channels, 3-bit select, dwell of 4.
module tb_decoder_scan_mux;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] ch_sel;
  logic [7:0] dec_out;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_scan_mux_if #(.N_CH(4), .SEL_W(3)) wr_if ();

  decoder_scan_mux #(
    .N_CH    (4),
    .SEL_W   (3),
    .PRESCALE(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .wr        (wr_if),
    .ch_sel    (ch_sel),
    .dec_out   (dec_out),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_write(input logic [1:0] ch, input logic [3:0] code);
    wr_if.in_valid = 1'b1;
    wr_if.in_ch    = ch;
    wr_if.in_code  = code;
    tick();
    wr_if.in_valid = 1'b0;
  endtask

  // Entered at frame cycle 1; checks every cycle including COMMIT (cycle 17).
  // Optional write at cycle wcyc, optional write held across COMMIT, optional abort.
  task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input int wcyc, input logic [1:0] wch,
                           input logic [3:0] wcode, input bit cwr, input int abort_cyc);
    logic [7:0] exp_dec;
    int         ch;
    for (int c = 1; c <= 16; c++) begin
      ch      = (c - 1) / 4;
      exp_dec = (ch == 0) ? e0 : (ch == 1) ? e1 : (ch == 2) ? e2 : e3;
      chk("scan_ch_sel", 32'(ch_sel), 32'(1) << ch);
      chk("scan_dec_out", 32'(dec_out), 32'(exp_dec));
      chk("scan_frame_done", 32'(frame_done), 32'(0));
      chk("scan_in_ready", 32'(wr_if.in_ready), 32'(1));
      if (c == abort_cyc) begin
        en = 1'b0;
        tick();
        chk("abort_ch_sel", 32'(ch_sel), 32'(0));
        chk("abort_dec_out", 32'(dec_out), 32'(0));
        chk("abort_frame_done", 32'(frame_done), 32'(0));
        return;
      end
      if (c == wcyc) begin
        wr_if.in_valid = 1'b1;
        wr_if.in_ch    = wch;
        wr_if.in_code  = wcode;
      end
      tick();
      wr_if.in_valid = 1'b0;
    end
    if (cwr) begin
      wr_if.in_valid = 1'b1;
      wr_if.in_ch    = 2'd1;
      wr_if.in_code  = 4'b1000;
    end
    chk("commit_frame_done", 32'(frame_done), 32'(1));
    chk("commit_ch_sel", 32'(ch_sel), 32'(0));
    chk("commit_dec_out", 32'(dec_out), 32'(0));
    chk("commit_in_ready", 32'(wr_if.in_ready), 32'(0));
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    en             = 1'b0;
    wr_if.in_valid = 1'b1;
    wr_if.in_ch    = 2'd1;
    wr_if.in_code  = 4'b1111;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", 32'(wr_if.in_ready), 32'(0));
      chk("rst_ch_sel", 32'(ch_sel), 32'(0));
      chk("rst_dec_out", 32'(dec_out), 32'(0));
      chk("rst_frame_done", 32'(frame_done), 32'(0));
    end
    reset          = 1'b0;
    wr_if.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(wr_if.in_ready), 32'(1));

    // Back-to-back writes to ch2: last one (select 5) wins.
    idle_write(2'd2, 4'b1010);
    idle_write(2'd2, 4'b1101);
    idle_write(2'd0, 4'b1001);
    idle_write(2'd3, 4'b1110);
    chk("idle_ch_sel", 32'(ch_sel), 32'(0));
    chk("idle_dec_out", 32'(dec_out), 32'(0));
    en = 1'b1;
    tick();

    // Frame 1: ch1 still 0 proves the write held during reset was dropped.
    run_frame(8'h02, 8'h00, 8'h20, 8'h40, 3, 2'd0, 4'b1011, 1'b0, 0);
    run_frame(8'h08, 8'h00, 8'h20, 8'h40, 0, 2'd0, 4'b0000, 1'b1, 0);
    run_frame(8'h08, 8'h00, 8'h20, 8'h40, 10, 2'd3, 4'b0111, 1'b0, 0);
    // Write in the last SCAN cycle must reach the very next frame.
    run_frame(8'h08, 8'h01, 8'h20, 8'h00, 16, 2'd1, 4'b1111, 1'b0, 0);
    run_frame(8'h08, 8'h80, 8'h20, 8'h00, 0, 2'd0, 4'b0000, 1'b0, 6);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aborted_idle_frame_done", 32'(frame_done), 32'(0));
      chk("aborted_idle_ch_sel", 32'(ch_sel), 32'(0));
    end
    idle_write(2'd1, 4'b1001);
    en = 1'b1;
    tick();
    run_frame(8'h08, 8'h02, 8'h20, 8'h00, 0, 2'd0, 4'b0000, 1'b0, 0);

    en = 1'b0;
    tick();
    chk("final_idle_ch_sel", 32'(ch_sel), 32'(0));
    chk("final_idle_frame_done", 32'(frame_done), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_mux.md
# decoder_scan_mux

Parametrised, time-multiplexed successor to the single-word decoder project. It holds N_CH coded words, each SEL_W select bits plus one enable bit, written through a valid/ready port into shadow registers. It scans the channels at a programmable dwell and drives one one-hot decoded output plus a one-hot channel strobe. Shadow-to-active commit happens only at frame boundaries, so a displayed frame never tears.

## Interface
- N_CH, 4: number of channels, ≥1.
- SEL_W, 3: select width. Decoded output width is 2**SEL_W. Code width is SEL_W+1.
- PRESCALE, 4: dwell per channel in clock cycles, ≥1.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  scan enable.
- in_valid  input  1  write request.
- in_ch  input  max(1,$clog2(N_CH))  target channel. Values ≥N_CH are accepted and ignored.
- in_code  input  SEL_W+1  bit[SEL_W] is enable; bits[SEL_W-1:0] are select.
- in_ready  output  1  write accept; a transfer occurs when in_valid && in_ready.
- ch_sel  output  N_CH  one-hot strobe for the channel being displayed.
- dec_out  output  2**SEL_W  one-hot decode of the active code for the displayed channel.
- frame_done  output  1  one-cycle pulse in the COMMIT state.

## Operation
- Storage: shadow[N_CH] and active[N_CH], each SEL_W+1 bits.
- Write: an accepted transfer sets shadow[in_ch] <= in_code at that clock edge.
- Decode: dec_out = active[idx][SEL_W] ? (1 << active[idx][SEL_W-1:0]) : 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - ch_sel = 0 and dec_out = 0.
  - active <= shadow every cycle.
  - en=1 moves to SCAN with idx=0 and pcnt=0.
- SCAN:
  - ch_sel = 1<<idx.
  - pcnt counts 0..PRESCALE-1.
  - When pcnt reaches PRESCALE-1: idx increments and pcnt clears.
  - When idx=N_CH-1 and pcnt=PRESCALE-1: go to COMMIT.
  - en=0 in any SCAN cycle: go to IDLE next cycle, abandoning the frame. No commit pulse is issued.
- COMMIT (exactly one cycle):
  - active <= shadow.
  - frame_done = 1, ch_sel = 0, dec_out = 0, in_ready = 0.
  - Next state is SCAN with idx=0 if en=1, otherwise IDLE.
- in_ready = (state != COMMIT) && !reset.
- Simultaneous events:
  - A write accepted in the last SCAN cycle lands in shadow and is committed in the immediately following COMMIT.
  - Back-to-back writes to the same channel: the last one wins.
- Reset:
  - All shadow and active words cleared, state = IDLE, idx = 0, pcnt = 0.
  - A reset asserted mid-frame discards the frame and all pending shadow data.

## Timing
- Outputs are Moore, decoded from registered state and active only. There is no combinational path from in_* or en to ch_sel or dec_out.
- Reset values: ch_sel = 0, dec_out = 0, frame_done = 0. in_ready = 0 while reset is high and 1 in the first cycle after it drops.
- Frame period = N_CH*PRESCALE + 1 cycles. For the defaults this is 17 cycles.
- First SCAN cycle is one clock after en rises in IDLE.
- Write-to-display latency in IDLE: a value written at edge t is in active at edge t+1.
- Write-to-display latency in SCAN: the value is visible from the first SCAN cycle after the next COMMIT.
- idx wraps N_CH-1 → 0 only through COMMIT. pcnt wraps PRESCALE-1 → 0.
- PRESCALE=1 with N_CH=1 is legal and alternates SCAN and COMMIT every cycle.

## Test plan
All scenarios use N_CH=4, SEL_W=3, PRESCALE=4.

- **Reset:** hold reset 3 cycles with in_valid=1.
  - During reset: in_ready = 0, ch_sel = 0, dec_out = 0, frame_done = 0.
  - After reset: writes were dropped and all active words are 0.
- **IDLE write then scan:** write ch2 = 4'b1101 in IDLE, then raise en.
  - Frame cycles 9–12: ch_sel = 4'b0100 and dec_out = 8'h20.
  - Other channels show dec_out = 0.
  - frame_done pulses at cycle 17.
- **Write during SCAN:** write ch0 = 4'b1011 during frame cycle 3.
  - The current frame still shows the old ch0 value.
  - From the next frame's cycle 1: ch_sel = 4'b0001 and dec_out = 8'h08.
- **Handshake in COMMIT:** hold in_valid=1, in_ch=1, code 4'b1000 across COMMIT.
  - in_ready = 0 in the COMMIT cycle.
  - Transfer occurs the following cycle.
  - ch1 shows dec_out = 8'h01 one frame later.
- **Disabled code:** write ch3 = 4'b0111.
  - During ch3 dwell: ch_sel = 4'b1000 and dec_out = 8'h00.
- **Mid-frame abort:** drop en at frame cycle 6.
  - Next cycle: ch_sel = 0, state IDLE, no frame_done.
  - Raise en again: scan restarts at ch0 with full dwell, showing shadow contents.
